rs485_tx_arbiter: RTL and testbench
===================================

# rs485_tx_arbiter

Transmit-side controller for the half-duplex RS485 link. It shares one UART byte transmitter among four on-chip requesters using round-robin arbitration, and sequences the RS485 driver enable. The enable rises a guard time before the first start bit and falls a guard time after the last stop bit. It sits between the requesters and the transmit serializer, on the divided clock used by the UART datapath.

## Interface
Parameters:
- CLK_FREQ, 921600: clk frequency in Hz (1843200 oscillator divided by 2).
- BAUD_RATE, 57600: line rate; BIT_CNT = CLK_FREQ / BAUD_RATE (16 at defaults).
- PRE_GUARD, 1: bit times DE is held before the first tx_start.
- POST_GUARD, 2: bit times DE is held after the last tx_done.
- MAX_BURST, 4: maximum bytes sent per grant before the arbiter re-arbitrates (1..15).
- WDOG_BITS, 12: watchdog limit in bit times (used only with the macro).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  4  per-requester byte-pending; held until that requester's grant pulse.
- req_data  input  32  byte for requester k on bits [8k+7:8k].
- grant  output  4  one-hot, one-cycle pulse: requester's byte was taken.
- tx_start  output  1  one-cycle pulse to the serializer.
- tx_data  output  8  byte to send; valid with tx_start, held until the next tx_start.
- tx_done  input  1  one-cycle pulse from the serializer after the stop bit.
- rx_active  input  1  receiver mid-frame (bus occupied by the far end).
- de  output  2  RS485 driver/receiver enable: 2'b11 when driving, else 2'b00.
- owner  output  2  index of the current or last granted requester.
- busy  output  1  high in every state except IDLE.
- err  output  1  one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, ARB, PRE, SEND, WAIT, POST.
- IDLE: de=00, busy=0. When |req is high and rx_active is low, go to ARB next cycle. If rx_active is high, stay in IDLE (no collision onto an incoming frame).
- ARB (1 cycle): pick the first set req bit, searching from ptr upward and wrapping (ptr+0, ptr+1, …, mod 4). Latch owner, clear burst_cnt, clear cnt, go to PRE. If req fell to 0 in the meantime, return to IDLE.
- PRE: de=11. Count PRE_GUARD*BIT_CNT cycles, then go to SEND.
- SEND (1 cycle): tx_start=1, tx_data=req_data[owner], grant[owner]=1, burst_cnt+1, go to WAIT.
- WAIT: hold de=11 until tx_done.
  - If req[owner] is high and burst_cnt<MAX_BURST, go to SEND on the next cycle.
  - Otherwise clear cnt and go to POST.
- POST: de=11 for POST_GUARD*BIT_CNT cycles. On exit de=00, ptr=owner+1 mod 4, go to IDLE.
- rx_active is ignored outside IDLE, because local echo is expected while driving.
- req changes outside IDLE/ARB do not affect owner. Only req[owner] is sampled, and only at tx_done.
- Simultaneous tx_done and watchdog expiry: tx_done wins, err stays 0.
- tx_done outside WAIT is ignored.

## Timing
- Reset values: state IDLE, de=00, grant=0000, tx_start=0, tx_data=00, owner=0, busy=0, err=0, ptr=0, counters=0.
- Reset asserted mid-frame drops de asynchronously. The serializer is reset on the same net.
- All outputs are registered.
- Latency from req (IDLE, rx_active=0) to de=11 is 2 cycles.
- Latency from de rise to tx_start is PRE_GUARD*BIT_CNT cycles.
- Latency from tx_done to the next tx_start in a burst is 1 cycle.
- Latency from the final tx_done to de fall is POST_GUARD*BIT_CNT+1 cycles.
- cnt is 10 bits, sized for WDOG_BITS*BIT_CNT ≤ 1023. burst_cnt is 4 bits.

## Configuration
- RS485_ARB_WDOG_EN defined:
  - In WAIT, cnt counts from 0.
  - If it reaches WDOG_BITS*BIT_CNT-1 with no tx_done, pulse err for 1 cycle and go to POST.
  - The aborted byte is not re-granted.
- RS485_ARB_WDOG_EN undefined:
  - WAIT holds indefinitely.
  - err is tied to 0.
  - The watchdog compare logic is absent.

## Test plan
- After reset, req=0001, data 0x5A → de=11 two cycles later; tx_start and grant=0001 16 cycles after that with tx_data=0x5A. After tx_done, de=00 33 cycles later.
- req=1111 held continuously, MAX_BURST=4:
  - owner 0 sends 4 bytes back-to-back (tx_start 1 cycle after each tx_done), then POST, then IDLE.
  - Next grant goes to owner 1, then 2, then 3, then 0.
- rx_active=1 with req=0010 → no de/tx_start while rx_active is high. Arbitration starts 1 cycle after rx_active falls.
- Reset pulled low during WAIT → de, busy and tx_start are 0 immediately. After release, state is IDLE and ptr=0.
- With RS485_ARB_WDOG_EN, tx_done withheld → err pulses at cycle 192 of WAIT; de falls 33 cycles later. Without the macro, de stays 11.
- tx_done and req[owner] drop on the same cycle with burst_cnt=1 → go to POST. No further grant goes to that requester.

Source files
------------

// File: rtl/rs485_tx_arbiter.sv
// Round-robin transmit arbiter for the half-duplex RS485 link, with driver-enable guard sequencing.
// Define RS485_ARB_WDOG_EN to add the tx_done watchdog (err pulse and abort to POST).
module rs485_tx_arbiter #(
  parameter int CLK_FREQ   = 921600,
  parameter int BAUD_RATE  = 57600,
  parameter int PRE_GUARD  = 1,
  parameter int POST_GUARD = 2,
  parameter int MAX_BURST  = 4,
  parameter int WDOG_BITS  = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  grant,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  input  logic        rx_active,
  output logic [1:0]  de,
  output logic [1:0]  owner,
  output logic        busy,
  output logic        err
);

  localparam int BIT_CNT = CLK_FREQ / BAUD_RATE;
  localparam logic [9:0] PRE_LAST  = 10'(PRE_GUARD * BIT_CNT - 1);
  // POST runs one cycle longer than the guard so de falls GUARD+1 cycles after tx_done.
  localparam logic [9:0] POST_LAST = 10'(POST_GUARD * BIT_CNT);
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);
`ifdef RS485_ARB_WDOG_EN
  localparam logic [9:0] WDOG_LAST = 10'(WDOG_BITS * BIT_CNT - 1);
`endif

  if (WDOG_BITS * BIT_CNT > 1023 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_cfg
    $error("rs485_tx_arbiter: WDOG_BITS*BIT_CNT must fit cnt and MAX_BURST must be 1..15");
  end

  typedef enum logic [2:0] {IDLE, ARB, PRE, SEND, WAIT, POST} state_t;

  state_t      state_reg;
  logic [9:0]  cnt_reg;
  logic [3:0]  burst_reg;
  logic [1:0]  ptr_reg;
  logic [3:0]  req_rot;
  logic [1:0]  pick_off;
  logic [1:0]  arb_pick;
  logic        go_send;

  // req rotated so bit 0 is the requester at ptr; lowest set bit wins.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign req_rot[gi] = req[ptr_reg + 2'(gi)];
  end

  always_comb begin
    pick_off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req_rot[i]) pick_off = 2'(i);
    end
  end

  assign arb_pick = ptr_reg + pick_off;

  assign go_send = (state_reg == PRE && cnt_reg == PRE_LAST) ||
                   (state_reg == WAIT && tx_done && req[owner] && burst_reg < BURST_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 10'd0;
      burst_reg <= 4'd0;
      ptr_reg   <= 2'd0;
      grant     <= 4'd0;
      tx_start  <= 1'b0;
      tx_data   <= 8'd0;
      de        <= 2'b00;
      owner     <= 2'd0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      grant    <= 4'd0;
      err      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|req && !rx_active) begin
            state_reg <= ARB;
            busy      <= 1'b1;
          end
        end
        ARB: begin
          if (|req) begin
            owner     <= arb_pick;
            burst_reg <= 4'd0;
            cnt_reg   <= 10'd0;
            de        <= 2'b11;
            state_reg <= PRE;
          end else begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        PRE: begin
          cnt_reg <= cnt_reg + 10'd1;
        end
        SEND: begin
          cnt_reg   <= 10'd0;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            cnt_reg   <= 10'd0;
            state_reg <= POST;
`ifdef RS485_ARB_WDOG_EN
          end else if (cnt_reg == WDOG_LAST) begin
            err       <= 1'b1;
            cnt_reg   <= 10'd0;
            state_reg <= POST;
          end else begin
            cnt_reg <= cnt_reg + 10'd1;
`endif
          end
        end
        POST: begin
          if (cnt_reg == POST_LAST) begin
            de        <= 2'b00;
            busy      <= 1'b0;
            ptr_reg   <= owner + 2'd1;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 10'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
      // Entering SEND overrides the PRE/WAIT next-state chosen above.
      if (go_send) begin
        tx_start  <= 1'b1;
        tx_data   <= req_data[{owner, 3'b000} +: 8];
        grant     <= 4'b0001 << owner;
        burst_reg <= burst_reg + 4'd1;
        state_reg <= SEND;
      end
    end
  end

endmodule

// File: tb/tb_rs485_tx_arbiter.sv
// Scoreboard bench for rs485_tx_arbiter: expected grants are queued with stimulus and
// popped whenever tx_start is seen.
module tb_rs485_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = 4'd0;
  logic [31:0] req_data = 32'd0;
  logic [3:0]  grant;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        rx_active = 1'b0;
  logic [1:0]  de;
  logic [1:0]  owner;
  logic        busy;
  logic        err;

  typedef struct packed {
    logic [1:0] own;
    logic [7:0] data;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] next_byte [4];
  logic       seen;

  always #5 clk = ~clk;

  rs485_tx_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .grant(grant),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done), .rx_active(rx_active),
    .de(de), .owner(owner), .busy(busy), .err(err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_data();
    req_data = {next_byte[3], next_byte[2], next_byte[1], next_byte[0]};
  endtask

  task automatic push_exp(input logic [1:0] own, input logic [7:0] data);
    exp_t e;
    e.own  = own;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!tx_start && n < 200) begin
      tick(1);
      n++;
    end
    check_val(tag, 32'(tx_start), 32'd1);
  endtask

  // Called on the SEND cycle: requester advances its byte, then the serializer finishes after gap cycles.
  task automatic serve(input logic drop, input int gap);
    for (int k = 0; k < 4; k++) begin
      if (grant[k]) begin
        next_byte[k] = next_byte[k] + 8'd1;
        if (drop) req[k] = 1'b0;
      end
    end
    set_data();
    tick(gap);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((de != 2'b00 || busy) && n < 400) begin
      tick(1);
      n++;
    end
    check_val(tag, 32'({busy, de}), 32'd0);
  endtask

  always @(negedge clk) begin
    if (reset && tx_start) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected_start", 32'(tx_start), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("sb_tx_data", 32'(tx_data), 32'(mon_e.data));
        check_val("sb_grant", 32'(grant), 32'(4'b0001 << mon_e.own));
        check_val("sb_owner", 32'(owner), 32'(mon_e.own));
        $display("txn owner=%0d data=0x%02h grant=%b", owner, tx_data, grant);
      end
    end
    if (reset && !tx_start && grant != 4'd0) check_val("grant_without_start", 32'(grant), 32'd0);
`ifndef RS485_ARB_WDOG_EN
    if (err) check_val("err_without_wdog", 32'(err), 32'd0);
`endif
  end

  initial begin
    #400000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 4; k++) next_byte[k] = 8'd0;
    tick(3);
    check_val("rst_de", 32'(de), 32'd0);
    check_val("rst_grant", 32'(grant), 32'd0);
    check_val("rst_tx_start", 32'(tx_start), 32'd0);
    check_val("rst_tx_data", 32'(tx_data), 32'd0);
    check_val("rst_owner", 32'(owner), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    reset = 1'b1;
    tick(2);

    // single byte: de 2 cycles after req, tx_start 16 later, de falls 33 after tx_done
    next_byte[0] = 8'h5A;
    set_data();
    push_exp(2'd0, 8'h5A);
    req = 4'b0001;
    tick(1);
    check_val("t1_de_in_arb", 32'(de), 32'd0);
    check_val("t1_busy_arb", 32'(busy), 32'd1);
    tick(1);
    check_val("t1_de_rise", 32'(de), 32'd3);
    tick(15);
    check_val("t1_pre_hold", 32'(tx_start), 32'd0);
    tick(1);
    check_val("t1_start_lat", 32'(tx_start), 32'd1);
    req = 4'b0000;
    tick(2);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    tick(32);
    check_val("t1_post_hold", 32'(de), 32'd3);
    tick(1);
    check_val("t1_de_fall", 32'(de), 32'd0);
    check_val("t1_busy_fall", 32'(busy), 32'd0);

    // rx_active blocks arbitration; ignored once the frame is under way
    rx_active = 1'b1;
    next_byte[1] = 8'hC3;
    set_data();
    push_exp(2'd1, 8'hC3);
    req = 4'b0010;
    seen = 1'b0;
    repeat (20) begin
      tick(1);
      seen = seen | (de != 2'b00) | tx_start | busy;
    end
    check_val("t2_rx_block", 32'(seen), 32'd0);
    rx_active = 1'b0;
    tick(1);
    check_val("t2_arb_start", 32'(busy), 32'd1);
    check_val("t2_de_arb", 32'(de), 32'd0);
    tick(1);
    check_val("t2_de_rise", 32'(de), 32'd3);
    rx_active = 1'b1;
    wait_start("t2_start");
    serve(1'b1, 3);
    wait_idle("t2_idle");
    rx_active = 1'b0;

    // reset during WAIT drops outputs at once
    next_byte[2] = 8'h33;
    set_data();
    push_exp(2'd2, 8'h33);
    req = 4'b0100;
    wait_start("t3_start");
    req = 4'b0000;
    tick(3);
    #2 reset = 1'b0;
    #1;
    check_val("t3_rst_de", 32'(de), 32'd0);
    check_val("t3_rst_busy", 32'(busy), 32'd0);
    check_val("t3_rst_start", 32'(tx_start), 32'd0);
    tick(1);
    reset = 1'b1;
    tick(1);
    check_val("t3_idle_busy", 32'(busy), 32'd0);
    check_val("t3_owner_rst", 32'(owner), 32'd0);

    // all requesting: bursts of 4 from owner 0 (ptr back at 0), then 1, 2, 3
    for (int k = 0; k < 4; k++) next_byte[k] = 8'(k * 16 + 1);
    set_data();
    for (int k = 0; k < 4; k++)
      for (int b = 0; b < 4; b++) push_exp(2'(k), 8'(k * 16 + 1 + b));
    req = 4'b1111;
    for (int f = 0; f < 16; f++) begin
      wait_start($sformatf("t4_start%0d", f));
      if (f == 15) req = 4'b0000;
      serve(1'b0, 2);
      if (f % 4 != 3) check_val($sformatf("t4_b2b%0d", f), 32'(tx_start), 32'd1);
      else check_val($sformatf("t4_burst_end%0d", f), 32'(tx_start), 32'd0);
    end
    wait_idle("t4_idle");

    // tx_done withheld
    next_byte[0] = 8'hA5;
    set_data();
    push_exp(2'd0, 8'hA5);
    req = 4'b0001;
    wait_start("t5_start");
    req = 4'b0000;
`ifdef RS485_ARB_WDOG_EN
    tick(192);
    check_val("t5_err_early", 32'(err), 32'd0);
    check_val("t5_de_wait", 32'(de), 32'd3);
    tick(1);
    check_val("t5_err", 32'(err), 32'd1);
    tick(1);
    check_val("t5_err_pulse", 32'(err), 32'd0);
    tick(31);
    check_val("t5_post_hold", 32'(de), 32'd3);
    tick(1);
    check_val("t5_de_fall", 32'(de), 32'd0);
`else
    tick(240);
    check_val("t5_de_hold", 32'(de), 32'd3);
    check_val("t5_busy_hold", 32'(busy), 32'd1);
    check_val("t5_err_zero", 32'(err), 32'd0);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
`endif
    wait_idle("t5_idle");

    // req[owner] falls together with tx_done after the first byte: no re-grant
    next_byte[3] = 8'h77;
    set_data();
    push_exp(2'd3, 8'h77);
    req = 4'b1000;
    wait_start("t6_start");
    tick(2);
    tx_done = 1'b1;
    req = 4'b0000;
    tick(1);
    tx_done = 1'b0;
    check_val("t6_no_regrant", 32'(tx_start), 32'd0);
    wait_idle("t6_idle");
    check_val("t6_owner_kept", 32'(owner), 32'd3);
    tick(20);
    check_val("t6_stay_idle", 32'(busy), 32'd0);

    check_val("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
